// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT pair scheduler: complex sample type,
// twiddle angle width and the full-turn angle constant.
package fft_pkg;

    localparam int unsigned CPLX_DW        = 16;
    localparam int unsigned TWID_FRAC_BITS = 15;
    localparam int unsigned ANGLE_W        = TWID_FRAC_BITS + 1;
    localparam longint unsigned FULL_TURN  = 64'd1 << ANGLE_W;

    // [0] real, [1] imaginary
    typedef logic signed [1:0][CPLX_DW-1:0] cplx_t;

    typedef enum logic {StFill, StPair} state_e;

    function automatic int unsigned angle_width(input int unsigned frac_bits);
        return frac_bits + 1;
    endfunction

endpackage

// File: rtl/fft_pair_buffer.sv
// N/2-entry holding buffer for the first half of a frame; one write port,
// one asynchronous read port, no reset.
module fft_pair_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]          raddr_i,
    output logic [1:0][DATA_WIDTH-1:0] rdata_o
);

    logic [1:0][DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fft_pair_scheduler.sv
// Radix-2 first-stage operand scheduler: buffers samples 0..N/2-1, then pairs
// each of samples N/2..N-1 with its partner and emits it with its twiddle angle.
module fft_pair_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 15,
    parameter int unsigned LOG2_N     = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic signed [1:0][DATA_WIDTH-1:0] in_data_i,
    output logic                              pair_valid_o,
    input  logic                              pair_ready_i,
    output logic signed [1:0][DATA_WIDTH-1:0] a_o,
    output logic signed [1:0][DATA_WIDTH-1:0] b_o,
    output logic [FRAC_BITS:0]                twid_o,
    output logic                              last_o
);

    localparam int unsigned HALF  = 2 ** (LOG2_N - 1);
    localparam int unsigned KW    = (LOG2_N > 1) ? LOG2_N - 1 : 1;
    localparam int unsigned AW    = angle_width(FRAC_BITS);
    localparam int unsigned SHIFT = AW - LOG2_N;

    state_e                     r_state;
    state_e                     w_state_next;
    logic [KW-1:0]              r_k;
    logic [KW-1:0]              w_k_next;
    logic                       r_pair_valid;
    logic                       w_pair_valid_next;
    logic [1:0][DATA_WIDTH-1:0] r_a;
    logic [1:0][DATA_WIDTH-1:0] r_b;
    logic [AW-1:0]              r_twid;
    logic                       r_last;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_load;
    logic                       w_buf_we;
    logic                       w_k_last;
    logic [AW-1:0]              w_twid;
    logic [1:0][DATA_WIDTH-1:0] w_buf_rdata;

    assign w_k_last = (r_k == KW'(HALF - 1));
    // Angle of W_N^k expressed as a negative fraction of a full turn
    assign w_twid   = AW'(0) - (AW'(r_k) << SHIFT);

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b1;
        w_buf_we     = 1'b0;
        w_load       = 1'b0;
        unique case (r_state)
            StFill: begin
                w_in_ready = 1'b1;
                w_buf_we   = in_valid_i;
                if (in_valid_i && w_k_last) begin
                    w_state_next = StPair;
                end
            end
            StPair: begin
                w_in_ready = !r_pair_valid || pair_ready_i;
                w_load     = in_valid_i && w_in_ready;
                if (w_load && w_k_last) begin
                    w_state_next = StFill;
                end
            end
            default: begin
                w_state_next = StFill;
            end
        endcase
        w_accept = in_valid_i && w_in_ready;
        w_k_next = r_k;
        if (w_accept) begin
            w_k_next = w_k_last ? '0 : r_k + KW'(1);
        end
        w_pair_valid_next = r_pair_valid;
        if (w_load) begin
            w_pair_valid_next = 1'b1;
        end else if (pair_ready_i) begin
            w_pair_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= StFill;
            r_k          <= '0;
            r_pair_valid <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_twid       <= '0;
            r_last       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_k          <= w_k_next;
            r_pair_valid <= w_pair_valid_next;
            if (w_load) begin
                r_a    <= w_buf_rdata;
                r_b    <= in_data_i;
                r_twid <= w_twid;
                r_last <= w_k_last;
            end
        end
    end

    fft_pair_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF),
        .ADDR_W     (KW)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (w_buf_we),
        .waddr_i (r_k),
        .wdata_i (in_data_i),
        .raddr_i (r_k),
        .rdata_o (w_buf_rdata)
    );

    assign in_ready_o   = w_in_ready;
    assign pair_valid_o = r_pair_valid;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign twid_o       = r_twid;
    assign last_o       = r_last;

endmodule
